// File: rtl/alumode_seq_pkg.sv
// -----------------------------------------------------------------------------
// dsp_ctrl_pkg
// Shared types and constants for the ALUMODE sequencer.
//   - state_t     : sequencer FSM states (IDLE, LOAD, RUN, DRAIN)
//   - alumode_t   : 4-bit ALUMODE control word
//   - ALU_*       : named ALUMODE operation codes
//   - ALU_ILLEGAL_LO/HI and alu_code_illegal(): reserved code range checked
//     when ALUMODE_SEQ_CHECK_EN is defined
// -----------------------------------------------------------------------------
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef logic [3:0] alumode_t;

  // Arithmetic operations
  localparam alumode_t ALU_ADD         = 4'b0000;  // Z + X + Y + CIN
  localparam alumode_t ALU_NOT_ADD_SUB = 4'b0001;  // -Z + (X + Y + CIN) - 1
  localparam alumode_t ALU_NOT_ADD     = 4'b0010;  // ~(Z + X + Y + CIN)
  localparam alumode_t ALU_SUB         = 4'b0011;  // Z - (X + Y + CIN)

  // Logic operations
  localparam alumode_t ALU_XOR         = 4'b0100;
  localparam alumode_t ALU_XNOR        = 4'b0101;
  localparam alumode_t ALU_XNOR_ALT    = 4'b0110;
  localparam alumode_t ALU_XOR_ALT     = 4'b0111;
  localparam alumode_t ALU_AND         = 4'b1100;
  localparam alumode_t ALU_AND_NOT     = 4'b1101;
  localparam alumode_t ALU_NAND        = 4'b1110;
  localparam alumode_t ALU_OR_NOT      = 4'b1111;

  // Reserved codes that the slice does not define
  localparam alumode_t ALU_ILLEGAL_LO  = 4'b1000;
  localparam alumode_t ALU_ILLEGAL_HI  = 4'b1011;

  function automatic logic alu_code_illegal(input alumode_t code);
    return (code >= ALU_ILLEGAL_LO) && (code <= ALU_ILLEGAL_HI);
  endfunction

endpackage

// File: rtl/alumode_seq_if.sv
// -----------------------------------------------------------------------------
// alumode_seq_if
// Command handshake and slice-control bundle of the ALUMODE sequencer.
//   Command side : CMD_VALID, CMD_READY, CMD_ALUMODE, CMD_COUNT, ABORT
//   Control side : ALUMODE, CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE
//   ERR          : only present when ALUMODE_SEQ_CHECK_EN is defined
// Modports:
//   master : command issuer / control consumer
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface alumode_seq_if #(
  parameter int CNT_W = 8
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic [3:0]       CMD_ALUMODE;
  logic [CNT_W-1:0] CMD_COUNT;
  logic             ABORT;
  logic [3:0]       ALUMODE;
  logic             CEALUMODE;
  logic             RSTALUMODE;
  logic             CEP;
  logic             RSTP;
  logic             BUSY;
  logic             DONE;
`ifdef ALUMODE_SEQ_CHECK_EN
  logic             ERR;

  modport master (
    output CMD_VALID, CMD_ALUMODE, CMD_COUNT, ABORT,
    input  CMD_READY, ALUMODE, CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE, ERR
  );

  modport slave (
    input  CMD_VALID, CMD_ALUMODE, CMD_COUNT, ABORT,
    output CMD_READY, ALUMODE, CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE, ERR
  );
`else
  modport master (
    output CMD_VALID, CMD_ALUMODE, CMD_COUNT, ABORT,
    input  CMD_READY, ALUMODE, CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE
  );

  modport slave (
    input  CMD_VALID, CMD_ALUMODE, CMD_COUNT, ABORT,
    output CMD_READY, ALUMODE, CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE
  );
`endif
endinterface

// File: rtl/alumode_seq_cnt.sv
// -----------------------------------------------------------------------------
// alumode_seq_cnt
// Loadable CNT_W-bit down-counter with a terminal-count flag. The sequencer
// reuses it for both the RUN (accumulate) and DRAIN (latency) phases.
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one (holds at zero)
//   tc_o       : terminal count, high while the count equals 1
// -----------------------------------------------------------------------------
module alumode_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count at 1 (not 0) so the phase that loaded N lasts exactly N
  // cycles and a full-scale count never has to represent N+1.
  assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/alumode_seq.sv
// -----------------------------------------------------------------------------
// alumode_seq
// Command-driven sequencer producing the ALUMODE control word and the
// clock-enable / reset strobes for the DSP slice ALUMODE and P registers.
// One command per CMD_VALID/CMD_READY handshake: load ALUMODE (LOAD, 1 cycle),
// enable P for max(CMD_COUNT,1) cycles (RUN), wait PIPE_LAT cycles (DRAIN),
// then pulse DONE in the first IDLE cycle. ABORT in any busy state returns
// to IDLE with one-cycle RSTALUMODE/RSTP strobes and ALUMODE cleared.
// Parameters:
//   CNT_W    : width of the repeat-count field
//   PIPE_LAT : cycles from last P-enable to stable P (0..15)
// Ports:
//   CLK : clock, rising edge
//   RST : asynchronous active-high reset
//   bus : alumode_seq_if.slave (command handshake + slice control outputs)
// Configuration macro:
//   ALUMODE_SEQ_CHECK_EN : reject codes 4'b1000..4'b1011 with a one-cycle ERR
//                          pulse instead of sequencing them; adds the ERR port.
// All outputs are registered.
// -----------------------------------------------------------------------------
module alumode_seq
  import dsp_ctrl_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic         CLK,
  input  logic         RST,
  alumode_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_V = CNT_W'(PIPE_LAT);

  state_t           state_q;
  alumode_t         alumode_q;
  logic             ceal_q;
  logic             rstal_q;
  logic             cep_q;
  logic             rstp_q;
  logic             busy_q;
  logic             done_q;
  logic             ready_q;

  logic             hs;
  logic             illegal;
  logic [CNT_W-1:0] cmd_cnt_eff;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tc;

  assign hs          = bus.CMD_VALID & ready_q;
  assign cmd_cnt_eff = (bus.CMD_COUNT == '0) ? CNT_W'(1) : bus.CMD_COUNT;

`ifdef ALUMODE_SEQ_CHECK_EN
  logic err_q;
  assign illegal = alu_code_illegal(bus.CMD_ALUMODE);
  assign bus.ERR = err_q;
`else
  assign illegal = 1'b0;
`endif

  // Counter control: the command count is loaded on acceptance, then the
  // same counter is reloaded with PIPE_LAT as RUN finishes.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = cmd_cnt_eff;
    case (state_q)
      IDLE: begin
        cnt_load = hs & ~bus.ABORT & ~illegal;
      end
      RUN: begin
        if (!bus.ABORT) begin
          if (cnt_tc) begin
            cnt_load = (PIPE_LAT != 0);
            cnt_val  = LAT_V;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      DRAIN: begin
        cnt_dec = ~bus.ABORT & ~cnt_tc;
      end
      default: ;
    endcase
  end

  alumode_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .tc_o       (cnt_tc)
  );

  // Outputs are computed for the state being entered, so every control
  // line is a flop and aligns with the state it describes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      alumode_q <= '0;
      ceal_q    <= 1'b0;
      rstal_q   <= 1'b0;
      cep_q     <= 1'b0;
      rstp_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
`ifdef ALUMODE_SEQ_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      // Single-cycle strobes default low
      ceal_q  <= 1'b0;
      rstal_q <= 1'b0;
      rstp_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALUMODE_SEQ_CHECK_EN
      err_q   <= 1'b0;
`endif
      if ((state_q != IDLE) && bus.ABORT) begin
        state_q   <= IDLE;
        alumode_q <= '0;
        rstal_q   <= 1'b1;
        rstp_q    <= 1'b1;
        cep_q     <= 1'b0;
        busy_q    <= 1'b0;
        ready_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            // ABORT alongside a handshake consumes and drops the command
            if (hs && !bus.ABORT) begin
              if (illegal) begin
`ifdef ALUMODE_SEQ_CHECK_EN
                err_q <= 1'b1;
`endif
              end else begin
                state_q   <= LOAD;
                alumode_q <= bus.CMD_ALUMODE;
                ceal_q    <= 1'b1;
                busy_q    <= 1'b1;
                ready_q   <= 1'b0;
              end
            end
          end
          LOAD: begin
            state_q <= RUN;
            cep_q   <= 1'b1;
          end
          RUN: begin
            if (cnt_tc) begin
              cep_q <= 1'b0;
              if (PIPE_LAT == 0) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
              end else begin
                state_q <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (cnt_tc) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.CMD_READY  = ready_q;
  assign bus.ALUMODE    = alumode_q;
  assign bus.CEALUMODE  = ceal_q;
  assign bus.RSTALUMODE = rstal_q;
  assign bus.CEP        = cep_q;
  assign bus.RSTP       = rstp_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

// File: tb/tb_alumode_seq.sv
// -----------------------------------------------------------------------------
// tb_alumode_seq
// Self-checking bench for alumode_seq. Three instances share clock and reset
// and differ only in PIPE_LAT (2, 0, 1); `sel` routes commands to one of them
// and muxes its outputs back. Expected DONE events (relative cycle + ALUMODE)
// are queued when a command is driven and popped when DONE is observed.
// Cycle j counts from the handshake edge: cycle 1 is the interval right after
// it. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_alumode_seq;
  import dsp_ctrl_pkg::*;

  localparam int CNT_W = 8;

  typedef struct packed {
    int         cyc;
    logic [3:0] code;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             valid;
  logic             abort;
  logic [3:0]       code;
  logic [CNT_W-1:0] cnt;
  int               sel;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alumode_seq_if #(.CNT_W(CNT_W)) bus_l2 ();
  alumode_seq_if #(.CNT_W(CNT_W)) bus_l0 ();
  alumode_seq_if #(.CNT_W(CNT_W)) bus_l1 ();

  alumode_seq #(.CNT_W(CNT_W), .PIPE_LAT(2)) u_lat2 (.CLK(clk), .RST(rst), .bus(bus_l2));
  alumode_seq #(.CNT_W(CNT_W), .PIPE_LAT(0)) u_lat0 (.CLK(clk), .RST(rst), .bus(bus_l0));
  alumode_seq #(.CNT_W(CNT_W), .PIPE_LAT(1)) u_lat1 (.CLK(clk), .RST(rst), .bus(bus_l1));

  assign bus_l2.CMD_VALID = valid & (sel == 0);
  assign bus_l0.CMD_VALID = valid & (sel == 1);
  assign bus_l1.CMD_VALID = valid & (sel == 2);
  assign bus_l2.ABORT     = abort & (sel == 0);
  assign bus_l0.ABORT     = abort & (sel == 1);
  assign bus_l1.ABORT     = abort & (sel == 2);
  assign bus_l2.CMD_ALUMODE = code;
  assign bus_l0.CMD_ALUMODE = code;
  assign bus_l1.CMD_ALUMODE = code;
  assign bus_l2.CMD_COUNT = cnt;
  assign bus_l0.CMD_COUNT = cnt;
  assign bus_l1.CMD_COUNT = cnt;

  logic [3:0] o_alumode;
  logic o_ceal, o_rstal, o_cep, o_rstp, o_busy, o_done, o_ready;
`ifdef ALUMODE_SEQ_CHECK_EN
  logic o_err;
`endif

  always_comb begin
    o_alumode = bus_l2.ALUMODE;   o_ceal = bus_l2.CEALUMODE; o_rstal = bus_l2.RSTALUMODE;
    o_cep     = bus_l2.CEP;       o_rstp = bus_l2.RSTP;      o_busy  = bus_l2.BUSY;
    o_done    = bus_l2.DONE;      o_ready = bus_l2.CMD_READY;
`ifdef ALUMODE_SEQ_CHECK_EN
    o_err     = bus_l2.ERR;
`endif
    if (sel == 1) begin
      o_alumode = bus_l0.ALUMODE;   o_ceal = bus_l0.CEALUMODE; o_rstal = bus_l0.RSTALUMODE;
      o_cep     = bus_l0.CEP;       o_rstp = bus_l0.RSTP;      o_busy  = bus_l0.BUSY;
      o_done    = bus_l0.DONE;      o_ready = bus_l0.CMD_READY;
`ifdef ALUMODE_SEQ_CHECK_EN
      o_err     = bus_l0.ERR;
`endif
    end else if (sel == 2) begin
      o_alumode = bus_l1.ALUMODE;   o_ceal = bus_l1.CEALUMODE; o_rstal = bus_l1.RSTALUMODE;
      o_cep     = bus_l1.CEP;       o_rstp = bus_l1.RSTP;      o_busy  = bus_l1.BUSY;
      o_done    = bus_l1.DONE;      o_ready = bus_l1.CMD_READY;
`ifdef ALUMODE_SEQ_CHECK_EN
      o_err     = bus_l1.ERR;
`endif
    end
  end

  function automatic int lat_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 0 : 1);
  endfunction

  // {ALUMODE, CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE, CMD_READY}
  localparam logic [10:0] RESET_VEC = {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_reset();
    logic [10:0] got;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      got = {o_alumode, o_ceal, o_rstal, o_cep, o_rstp, o_busy, o_done, o_ready};
      n_cmp++;
      if (got !== RESET_VEC) begin
        n_bad++;
        $display("FAIL reset_state dut=%0d got=%b exp=%b", s, got, RESET_VEC);
      end
    end
    sel = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Normal command on instance s; full cycle-by-cycle model of the timeline.
  task automatic test_sequence(input int s, input logic [3:0] c, input int n);
    int L  = lat_of(s);
    int ne = (n == 0) ? 1 : n;
    int jd = 2 + ne + L;
    logic [5:0] got, expv;
    exp_t e;
    sel = s;
    @(negedge clk);
    valid = 1'b1; code = c; cnt = CNT_W'(n);
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before_cmd got=%b exp=1", o_ready);
    end
    exp_q.push_back('{cyc: jd, code: c});
    for (int j = 1; j <= jd + 3; j++) begin
      @(negedge clk);
      got  = {o_ceal, o_cep, o_ready, o_busy, o_rstal, o_rstp};
      expv = {(j == 1), (j >= 2 && j <= 1 + ne), (j >= jd), (j < jd), 1'b0, 1'b0};
      n_cmp++;
      if (got !== expv) begin
        n_bad++;
        $display("FAIL seq_ctrl lat=%0d n=%0d j=%0d got=%b exp=%b", L, n, j, got, expv);
      end
      n_cmp++;
      if (o_alumode !== c) begin
        n_bad++;
        $display("FAIL seq_alumode j=%0d got=%h exp=%h", j, o_alumode, c);
      end
      if (o_done === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected j=%0d got=1 exp=0", j);
        end else begin
          e = exp_q.pop_front();
          if (j != e.cyc || o_alumode !== e.code) begin
            n_bad++;
            $display("FAIL done_sb j=%0d code=%h exp_j=%0d exp_code=%h", j, o_alumode, e.cyc, e.code);
          end
        end
      end
      if (j == 1) valid = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL done_missing pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_basic();
    test_sequence(0, ALU_SUB, 3);
  endtask

  task automatic test_count0();
    test_sequence(1, ALU_XNOR, 0);
  endtask

  task automatic test_count_max();
    test_sequence(1, ALU_AND, 255);
  endtask

  task automatic test_reset_midrun();
    logic [10:0] got;
    sel = 0;
    @(negedge clk);
    valid = 1'b1; code = ALU_SUB; cnt = 8'd5;
    @(negedge clk);  // cycle 1
    valid = 1'b0;
    repeat (2) @(negedge clk);  // cycle 3, mid-RUN
    n_cmp++;
    if (o_cep !== 1'b1) begin
      n_bad++;
      $display("FAIL midrun_cep got=%b exp=1", o_cep);
    end
    #2 rst = 1'b1;
    #1;
    got = {o_alumode, o_ceal, o_rstal, o_cep, o_rstp, o_busy, o_done, o_ready};
    n_cmp++;
    if (got !== RESET_VEC) begin
      n_bad++;
      $display("FAIL async_reset got=%b exp=%b", got, RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      got = {o_alumode, o_ceal, o_rstal, o_cep, o_rstp, o_busy, o_done, o_ready};
      n_cmp++;
      if (got !== RESET_VEC) begin
        n_bad++;
        $display("FAIL post_reset j=%0d got=%b exp=%b", j, got, RESET_VEC);
      end
    end
  endtask

  task automatic test_abort();
    logic [6:0] got;
    exp_t e;
    sel = 0;
    @(negedge clk);
    valid = 1'b1; code = ALU_NOT_ADD_SUB; cnt = 8'd5;
    @(negedge clk);  // cycle 1
    valid = 1'b0;
    repeat (2) @(negedge clk);  // cycle 3 = second RUN cycle
    abort = 1'b1;
    @(negedge clk);  // cycle 4
    abort = 1'b0;
    got = {o_rstal, o_rstp, o_ceal, o_cep, o_busy, o_ready, o_done};
    n_cmp++;
    if (got !== 7'b1100010 || o_alumode !== 4'b0000) begin
      n_bad++;
      $display("FAIL abort_strobe got=%b alumode=%h exp=1100010 alumode=0", got, o_alumode);
    end
    // Next command in the cycle right after the abort
    valid = 1'b1; code = ALU_XNOR_ALT; cnt = 8'd1;
    exp_q.push_back('{cyc: 9, code: ALU_XNOR_ALT});
    for (int j = 5; j <= 12; j++) begin
      @(negedge clk);
      got = {o_rstal, o_rstp, o_ceal, o_cep, o_busy, o_ready, 1'b0};
      n_cmp++;
      if (got !== {1'b0, 1'b0, (j == 5), (j == 6), (j < 9), (j >= 9), 1'b0} || o_alumode !== ALU_XNOR_ALT) begin
        n_bad++;
        $display("FAIL after_abort j=%0d got=%b alumode=%h", j, got, o_alumode);
      end
      if (o_done === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected j=%0d got=1 exp=0", j);
        end else begin
          e = exp_q.pop_front();
          if (j != e.cyc || o_alumode !== e.code) begin
            n_bad++;
            $display("FAIL done_sb j=%0d code=%h exp_j=%0d exp_code=%h", j, o_alumode, e.cyc, e.code);
          end
        end
      end
      if (j == 5) valid = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL done_missing pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_abort_handshake();
    logic [3:0] got;
    sel = 0;
    @(negedge clk);
    valid = 1'b1; abort = 1'b1; code = ALU_ADD; cnt = 8'd2;
    @(negedge clk);
    valid = 1'b0; abort = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      got = {o_ceal, o_cep, o_busy, o_done};
      n_cmp++;
      if (got !== 4'b0000 || o_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_hs_drop j=%0d got=%b ready=%b exp=0000 ready=1", j, got, o_ready);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] got, expv;
    logic [3:0] exp_code;
    exp_t e;
    sel = 2;
    @(negedge clk);
    valid = 1'b1; code = ALU_ADD; cnt = 8'd2;
    exp_q.push_back('{cyc: 5, code: ALU_ADD});
    exp_q.push_back('{cyc: 10, code: ALU_AND});
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      got      = {o_ceal, o_cep, o_ready, o_busy};
      expv     = {(j == 1 || j == 6), ((j >= 2 && j <= 3) || (j >= 7 && j <= 8)),
                  (j == 5 || j >= 10), !(j == 5 || j >= 10)};
      exp_code = (j <= 5) ? ALU_ADD : ALU_AND;
      n_cmp++;
      if (got !== expv || o_alumode !== exp_code) begin
        n_bad++;
        $display("FAIL b2b j=%0d got=%b alumode=%h exp=%b alumode=%h", j, got, o_alumode, expv, exp_code);
      end
      if (o_done === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected j=%0d got=1 exp=0", j);
        end else begin
          e = exp_q.pop_front();
          if (j != e.cyc || o_alumode !== e.code) begin
            n_bad++;
            $display("FAIL done_sb j=%0d code=%h exp_j=%0d exp_code=%h", j, o_alumode, e.cyc, e.code);
          end
        end
      end
      if (j == 1) code = ALU_AND;
      if (j == 6) valid = 1'b0;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL done_missing pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_code1000();
`ifdef ALUMODE_SEQ_CHECK_EN
    logic [5:0] got;
    sel = 0;
    @(negedge clk);
    valid = 1'b1; code = 4'b1000; cnt = 8'd3;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      valid = 1'b0;
      got = {o_err, o_ceal, o_cep, o_done, o_busy, o_ready};
      n_cmp++;
      if (got !== {(j == 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        n_bad++;
        $display("FAIL illegal_code j=%0d got=%b exp_err=%b", j, got, (j == 1));
      end
    end
`else
    test_sequence(0, 4'b1000, 2);
`endif
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; abort = 1'b0; code = '0; cnt = '0; sel = 0;
    test_reset();
    test_basic();
    test_count0();
    test_count_max();
    test_reset_midrun();
    test_abort();
    test_abort_handshake();
    test_back_to_back();
    test_code1000();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alumode_seq.md
# alumode_seq

Command-driven sequencer that generates the ALUMODE control word and the clock-enable/reset strobes consumed by the DSP slice's ALUMODE and P registers. It sits upstream of the slice's control-register bank. It accepts one ALU operation per valid/ready handshake and loads the ALUMODE register. It then enables the P register for a programmed number of accumulate cycles and waits out the datapath latency. Finally it signals completion.

## Interface
- CNT_W, 8, width of the repeat-count field.
- PIPE_LAT, 2, cycles from the last P-enable until the result is stable at P; range 0..15.
- CLK  in  1  single clock; all logic on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_ALUMODE  in  4  ALU operation code to load.
- CMD_COUNT  in  CNT_W  number of P-enable cycles; 0 is treated as 1.
- ABORT  in  1  cancel the current operation.
- ALUMODE  out  4  word driven to the ALUMODE register input.
- CEALUMODE  out  1  ALUMODE register clock enable.
- RSTALUMODE  out  1  ALUMODE register reset strobe.
- CEP  out  1  P register clock enable.
- RSTP  out  1  P register reset strobe.
- BUSY  out  1  high in any state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle illegal-code pulse; only present with ALUMODE_SEQ_CHECK_EN.

## Operation
- All outputs are registered.
- Reset values:
  - ALUMODE = 0.
  - CEALUMODE, RSTALUMODE, CEP, RSTP, BUSY, DONE and ERR = 0.
  - CMD_READY = 1.
  - State = IDLE.
- IDLE:
  - CMD_READY = 1.
  - A handshake (CMD_VALID & CMD_READY) captures CMD_ALUMODE and max(CMD_COUNT, 1), then moves to LOAD.
- LOAD, 1 cycle:
  - ALUMODE = captured code; CEALUMODE = 1; CEP = 0.
  - Moves to RUN.
- RUN, N cycles:
  - CEP = 1 and the counter decrements each cycle.
  - When the counter reaches 1, moves to DRAIN, or to IDLE with DONE when PIPE_LAT = 0.
- DRAIN, PIPE_LAT cycles:
  - All enables are 0.
  - On expiry, moves to IDLE with DONE = 1 in the first IDLE cycle.
- Output hold:
  - ALUMODE keeps the last loaded code after completion; it is not cleared.
  - Only reset or ABORT changes it outside LOAD.
- ABORT, in any non-IDLE state:
  - Next cycle: RSTALUMODE = 1, RSTP = 1, ALUMODE = 0, all CEs = 0, state = IDLE.
  - DONE is not asserted.
- ABORT in IDLE, or in the same cycle as a handshake: ABORT wins and the command is dropped, but it is still consumed.
- Counter arithmetic: unsigned, CNT_W bits; a count of 2^CNT_W-1 must run fully with no wrap.
- Async reset mid-operation:
  - Immediately forces the reset values.
  - No DONE is issued and no partial CE cycle follows release.

## Timing
With the handshake at edge k and N = effective count:
- LOAD: cycle k+1.
- RUN: cycles k+2 .. k+1+N.
- DRAIN: cycles k+2+N .. k+1+N+PIPE_LAT.
- DONE and CMD_READY: both high in cycle k+2+N+PIPE_LAT.
- Back-to-back: a new command may be accepted in the DONE cycle, so throughput is N+PIPE_LAT+2 cycles per command.
- CMD_READY is low from k+1 until IDLE is re-entered.

## Configuration
- Macro: ALUMODE_SEQ_CHECK_EN.
- Defined:
  - Codes 4'b1000–4'b1011 are illegal.
  - An illegal command is accepted but skips LOAD and RUN.
  - ERR pulses in cycle k+1, the state returns to IDLE (CMD_READY = 1 in k+1), and there is no DONE or CE.
- Undefined:
  - The ERR port is absent and no check is made.
  - Every code is sequenced normally.

## Structure
- Package dsp_ctrl_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DRAIN);
  - named 4-bit ALUMODE constants (ADD, SUB, NOT_ADD_SUB, logic codes);
  - the illegal-code range constants.
- One sub-module, alumode_seq_cnt: a loadable CNT_W-bit down-counter with a terminal-count flag, reused for both the RUN and DRAIN phases.

## Test plan
1. Reset: assert RST mid-RUN with count 5 → all outputs 0 and CMD_READY = 1 within the same cycle; no DONE after release.
2. CMD_ALUMODE = 0011, COUNT = 3, PIPE_LAT = 2, handshake at edge 0 → CEALUMODE = 1 with ALUMODE = 0011 in cycle 1; CEP high in cycles 2–4; DONE and CMD_READY in cycle 7; ALUMODE still 0011 afterwards.
3. COUNT = 0, PIPE_LAT = 0 → CEP high in cycle 2 only; DONE in cycle 3.
4. ABORT in the second RUN cycle → RSTALUMODE = RSTP = 1 for exactly one cycle; ALUMODE = 0; no DONE; next command accepted the following cycle.
5. CMD_ALUMODE = 1000 with ALUMODE_SEQ_CHECK_EN → ERR in cycle 1 and no CEALUMODE/CEP; without the macro → a normal sequence with ALUMODE = 1000.
6. CMD_VALID held high over two commands (COUNT = 2, PIPE_LAT = 1) → second handshake in the first DONE cycle (cycle 5); second LOAD in cycle 6.
